// File: rtl/ysyx_22040895_wb_queue_pkg.sv
// rtl/ysyx_22040895_wb_queue_pkg.sv - shared register-file widths and enable levels
// Contents: RegAddrBus/RegBus widths, WriteEnable/RstEnable levels,
//           register address/data typedefs used by the writeback queue.
package ysyx_22040895_wb_queue_pkg;

  localparam int RegAddrBus = 5;
  localparam int RegBus     = 64;

  localparam logic WriteEnable = 1'b1;
  localparam logic RstEnable   = 1'b1;

  typedef logic [RegAddrBus-1:0] reg_addr_t;
  typedef logic [RegBus-1:0]     reg_data_t;

endpackage

// File: rtl/ysyx_22040895_wb_fwd_lookup.sv
// rtl/ysyx_22040895_wb_fwd_lookup.sv - youngest-match bypass search over the writeback queue
// Ports:
//   rd_arr, data_arr : queue storage, indexed by physical slot
//   head, count      : oldest slot and number of valid entries
//   addr             : register being looked up (x0 never hits)
//   hit, data        : match flag and data of the youngest matching entry (0 on miss)
module ysyx_22040895_wb_fwd_lookup
  import ysyx_22040895_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic [DEPTH-1:0][RegAddrBus-1:0] rd_arr,
  input  logic [DEPTH-1:0][RegBus-1:0]     data_arr,
  input  logic [PW-1:0]                    head,
  input  logic [CW-1:0]                    count,
  input  logic [RegAddrBus-1:0]            addr,
  output logic                             hit,
  output logic [RegBus-1:0]                data
);

  logic [PW-1:0] idx;

  // Walk entries from oldest to youngest; a later match overwrites an
  // earlier one, so the result is always the youngest matching entry.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) && (addr != '0) && (rd_arr[idx] == addr)) begin
        hit  = 1'b1;
        data = data_arr[idx];
      end
    end
  end

endmodule

// File: rtl/ysyx_22040895_wb_queue.sv
// rtl/ysyx_22040895_wb_queue.sv - pending-writeback FIFO merging LSU and ALU results
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   lsu_valid_i/ready_o/rd_i/data_i  : load-result source (older when both fire)
//   alu_valid_i/ready_o/rd_i/data_i  : ALU-result source
//   we_o, waddr_o, wdata_o           : regfile write port, shows the head entry
//   fwdN_addr_i/hit_o/data_o         : two operand bypass lookups
//   count_o                          : current occupancy
module ysyx_22040895_wb_queue
  import ysyx_22040895_wb_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [RegAddrBus-1:0] lsu_rd_i,
  input  logic [RegBus-1:0]     lsu_data_i,
  input  logic                  alu_valid_i,
  output logic                  alu_ready_o,
  input  logic [RegAddrBus-1:0] alu_rd_i,
  input  logic [RegBus-1:0]     alu_data_i,
  output logic                  we_o,
  output logic [RegAddrBus-1:0] waddr_o,
  output logic [RegBus-1:0]     wdata_o,
  input  logic [RegAddrBus-1:0] fwd1_addr_i,
  input  logic [RegAddrBus-1:0] fwd2_addr_i,
  output logic                  fwd1_hit_o,
  output logic                  fwd2_hit_o,
  output logic [RegBus-1:0]     fwd1_data_o,
  output logic [RegBus-1:0]     fwd2_data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_M1   = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_M2   = CW'(DEPTH - 2);

  // Entry storage is deliberately left out of reset; count/head/tail
  // alone decide which slots are meaningful.
  logic [DEPTH-1:0][RegAddrBus-1:0] rd_mem;
  logic [DEPTH-1:0][RegBus-1:0]     data_mem;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;

  logic          in_rst;
  logic          lsu_push;
  logic          alu_push;
  logic          pop;
  logic [PW-1:0] alu_slot;

  assign in_rst = (rst == RstEnable);

  // Ready depends only on the registered count, never on this cycle's pop,
  // so the regfile side has no combinational path back to the sources.
  // The ALU keeps one slot in reserve for the LSU when the queue is nearly
  // full, because the LSU wins a same-cycle tie.
  assign lsu_ready_o = !in_rst && (count < CNT_FULL);
  assign alu_ready_o = !in_rst &&
                       ((count <= CNT_M2) || ((count == CNT_M1) && !lsu_valid_i));

  // Writes to x0 complete the handshake but are dropped.
  assign lsu_push = lsu_valid_i && lsu_ready_o && (lsu_rd_i != '0);
  assign alu_push = alu_valid_i && alu_ready_o && (alu_rd_i != '0);

  // The regfile never stalls, so a valid head always retires this cycle.
  assign pop = !in_rst && (count != '0);

  // The ALU entry lands behind the LSU entry when both are pushed.
  assign alu_slot = tail + PW'(lsu_push);

  always_ff @(posedge clk) begin
    if (lsu_push) begin
      rd_mem[tail]   <= lsu_rd_i;
      data_mem[tail] <= lsu_data_i;
    end
    if (alu_push) begin
      rd_mem[alu_slot]   <= alu_rd_i;
      data_mem[alu_slot] <= alu_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (in_rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        head <= head + PW'(1);
      end
      tail  <= tail + PW'(lsu_push) + PW'(alu_push);
      count <= count + CW'(lsu_push) + CW'(alu_push) - CW'(pop);
    end
  end

  assign we_o    = pop ? WriteEnable : ~WriteEnable;
  assign waddr_o = pop ? rd_mem[head]   : '0;
  assign wdata_o = pop ? data_mem[head] : '0;

  // Forced to zero in reset, which also masks the bypass lookups below.
  assign count_o = in_rst ? '0 : count;

  ysyx_22040895_wb_fwd_lookup #(
    .DEPTH (DEPTH)
  ) u_fwd1 (
    .rd_arr   (rd_mem),
    .data_arr (data_mem),
    .head     (head),
    .count    (count_o),
    .addr     (fwd1_addr_i),
    .hit      (fwd1_hit_o),
    .data     (fwd1_data_o)
  );

  ysyx_22040895_wb_fwd_lookup #(
    .DEPTH (DEPTH)
  ) u_fwd2 (
    .rd_arr   (rd_mem),
    .data_arr (data_mem),
    .head     (head),
    .count    (count_o),
    .addr     (fwd2_addr_i),
    .hit      (fwd2_hit_o),
    .data     (fwd2_data_o)
  );

endmodule

// File: tb/tb_ysyx_22040895_wb_queue.sv
// tb/tb_ysyx_22040895_wb_queue.sv - directed self-checking bench for the writeback queue
module tb_ysyx_22040895_wb_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_rd_i;
  logic [63:0] lsu_data_i;
  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [4:0]  alu_rd_i;
  logic [63:0] alu_data_i;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [63:0] wdata_o;
  logic [4:0]  fwd1_addr_i;
  logic [4:0]  fwd2_addr_i;
  logic        fwd1_hit_o;
  logic        fwd2_hit_o;
  logic [63:0] fwd1_data_o;
  logic [63:0] fwd2_data_o;
  logic [2:0]  count_o;

  int passed = 0;
  int total  = 0;

  logic [68:0] commit_q[$];
  logic [68:0] exp_q[$];

  ysyx_22040895_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .lsu_valid_i (lsu_valid_i),
    .lsu_ready_o (lsu_ready_o),
    .lsu_rd_i    (lsu_rd_i),
    .lsu_data_i  (lsu_data_i),
    .alu_valid_i (alu_valid_i),
    .alu_ready_o (alu_ready_o),
    .alu_rd_i    (alu_rd_i),
    .alu_data_i  (alu_data_i),
    .we_o        (we_o),
    .waddr_o     (waddr_o),
    .wdata_o     (wdata_o),
    .fwd1_addr_i (fwd1_addr_i),
    .fwd2_addr_i (fwd2_addr_i),
    .fwd1_hit_o  (fwd1_hit_o),
    .fwd2_hit_o  (fwd2_hit_o),
    .fwd1_data_o (fwd1_data_o),
    .fwd2_data_o (fwd2_data_o),
    .count_o     (count_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Whatever the write port shows mid-cycle is retired at the next rising edge.
  always @(negedge clk) begin
    #2;
    if (we_o === 1'b1) commit_q.push_back({waddr_o, wdata_o});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    lsu_valid_i = 1'b0;
    lsu_rd_i    = '0;
    lsu_data_i  = '0;
    alu_valid_i = 1'b0;
    alu_rd_i    = '0;
    alu_data_i  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd3; lsu_data_i = 64'h33;
    alu_valid_i = 1'b1; alu_rd_i = 5'd4; alu_data_i = 64'h44;
    fwd1_addr_i = 5'd3; fwd2_addr_i = 5'd4;
    @(negedge clk); #1;
    total++; if (lsu_ready_o !== 1'b0) $display("FAIL rst_lsu_ready: got %0b exp 0", lsu_ready_o); else passed++;
    total++; if (alu_ready_o !== 1'b0) $display("FAIL rst_alu_ready: got %0b exp 0", alu_ready_o); else passed++;
    total++; if (we_o !== 1'b0) $display("FAIL rst_we: got %0b exp 0", we_o); else passed++;
    total++; if (waddr_o !== 5'd0) $display("FAIL rst_waddr: got %0h exp 0", waddr_o); else passed++;
    total++; if (wdata_o !== 64'd0) $display("FAIL rst_wdata: got %0h exp 0", wdata_o); else passed++;
    total++; if (fwd1_hit_o !== 1'b0) $display("FAIL rst_fwd1_hit: got %0b exp 0", fwd1_hit_o); else passed++;
    total++; if (fwd2_hit_o !== 1'b0) $display("FAIL rst_fwd2_hit: got %0b exp 0", fwd2_hit_o); else passed++;
    total++; if (fwd1_data_o !== 64'd0) $display("FAIL rst_fwd1_data: got %0h exp 0", fwd1_data_o); else passed++;
    total++; if (fwd2_data_o !== 64'd0) $display("FAIL rst_fwd2_data: got %0h exp 0", fwd2_data_o); else passed++;
    total++; if (count_o !== 3'd0) $display("FAIL rst_count: got %0d exp 0", count_o); else passed++;
    @(negedge clk); #1;
    total++; if (count_o !== 3'd0) $display("FAIL rst_count_held: got %0d exp 0", count_o); else passed++;
    idle();
    fwd1_addr_i = '0; fwd2_addr_i = '0;
    @(negedge clk);
  endtask

  task automatic test_single_push();
    commit_q.delete();
    rst = 1'b0;
    alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 64'h1234;
    #1;
    total++; if (alu_ready_o !== 1'b1) $display("FAIL single_alu_ready: got %0b exp 1", alu_ready_o); else passed++;
    total++; if (we_o !== 1'b0) $display("FAIL single_we_before: got %0b exp 0", we_o); else passed++;
    @(negedge clk); idle(); #1;
    total++; if (we_o !== 1'b1) $display("FAIL single_we: got %0b exp 1", we_o); else passed++;
    total++; if (waddr_o !== 5'd5) $display("FAIL single_waddr: got %0h exp 5", waddr_o); else passed++;
    total++; if (wdata_o !== 64'h1234) $display("FAIL single_wdata: got %0h exp 1234", wdata_o); else passed++;
    total++; if (count_o !== 3'd1) $display("FAIL single_count1: got %0d exp 1", count_o); else passed++;
    @(negedge clk); #1;
    total++; if (count_o !== 3'd0) $display("FAIL single_count0: got %0d exp 0", count_o); else passed++;
    total++; if (we_o !== 1'b0) $display("FAIL single_we_after: got %0b exp 0", we_o); else passed++;
    total++; if (waddr_o !== 5'd0) $display("FAIL single_waddr_after: got %0h exp 0", waddr_o); else passed++;
    @(negedge clk);
    total++; if (commit_q.size() != 1) $display("FAIL single_commits: got %0d exp 1", commit_q.size()); else passed++;
  endtask

  task automatic test_dual_push();
    commit_q.delete();
    exp_q = '{{5'd10, 64'hA10}, {5'd11, 64'hA11}, {5'd12, 64'hA12},
              {5'd13, 64'hA13}, {5'd1, 64'hA01}, {5'd2, 64'hA02}};
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd10; lsu_data_i = 64'hA10;
    alu_valid_i = 1'b1; alu_rd_i = 5'd11; alu_data_i = 64'hA11;
    #1;
    total++; if (alu_ready_o !== 1'b1) $display("FAIL dual_alu_ready_c0: got %0b exp 1", alu_ready_o); else passed++;
    @(negedge clk);
    lsu_rd_i = 5'd12; lsu_data_i = 64'hA12;
    alu_rd_i = 5'd13; alu_data_i = 64'hA13;
    #1;
    total++; if (count_o !== 3'd2) $display("FAIL dual_count2: got %0d exp 2", count_o); else passed++;
    total++; if (alu_ready_o !== 1'b1) $display("FAIL dual_alu_ready_c2: got %0b exp 1", alu_ready_o); else passed++;
    @(negedge clk);
    lsu_rd_i = 5'd1; lsu_data_i = 64'hA01;
    alu_rd_i = 5'd2; alu_data_i = 64'hA02;
    #1;
    total++; if (count_o !== 3'd3) $display("FAIL dual_count3: got %0d exp 3", count_o); else passed++;
    total++; if (lsu_ready_o !== 1'b1) $display("FAIL dual_lsu_ready_c3: got %0b exp 1", lsu_ready_o); else passed++;
    total++; if (alu_ready_o !== 1'b0) $display("FAIL dual_alu_ready_c3: got %0b exp 0", alu_ready_o); else passed++;
    @(negedge clk);
    lsu_valid_i = 1'b0; lsu_rd_i = '0; lsu_data_i = '0;
    #1;
    total++; if (count_o !== 3'd3) $display("FAIL dual_count_after_lsu: got %0d exp 3", count_o); else passed++;
    total++; if (alu_ready_o !== 1'b1) $display("FAIL dual_alu_retry_ready: got %0b exp 1", alu_ready_o); else passed++;
    @(negedge clk); idle(); #1;
    total++; if (count_o !== 3'd3) $display("FAIL dual_count_after_alu: got %0d exp 3", count_o); else passed++;
    repeat (4) @(negedge clk);
    #1;
    total++; if (count_o !== 3'd0) $display("FAIL dual_drained: got %0d exp 0", count_o); else passed++;
    total++; if (commit_q.size() != exp_q.size()) $display("FAIL dual_commit_count: got %0d exp %0d", commit_q.size(), exp_q.size()); else passed++;
    for (int k = 0; k < exp_q.size(); k++) begin
      total++;
      if (k >= commit_q.size() || commit_q[k] !== exp_q[k])
        $display("FAIL dual_commit_%0d: got %0h exp %0h", k, (k < commit_q.size()) ? commit_q[k] : 69'h0, exp_q[k]);
      else passed++;
    end
    @(negedge clk);
  endtask

  task automatic test_order_fwd();
    commit_q.delete();
    exp_q = '{{5'd7, 64'hA}, {5'd7, 64'hB}};
    fwd1_addr_i = 5'd7;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd7; lsu_data_i = 64'hA;
    alu_valid_i = 1'b1; alu_rd_i = 5'd7; alu_data_i = 64'hB;
    #1;
    total++; if (fwd1_hit_o !== 1'b0) $display("FAIL fwd_same_cycle_hit: got %0b exp 0", fwd1_hit_o); else passed++;
    @(negedge clk); idle(); #1;
    total++; if (count_o !== 3'd2) $display("FAIL fwd_count2: got %0d exp 2", count_o); else passed++;
    total++; if (fwd1_hit_o !== 1'b1) $display("FAIL fwd_hit_two: got %0b exp 1", fwd1_hit_o); else passed++;
    total++; if (fwd1_data_o !== 64'hB) $display("FAIL fwd_youngest: got %0h exp b", fwd1_data_o); else passed++;
    total++; if (wdata_o !== 64'hA) $display("FAIL fwd_head_first: got %0h exp a", wdata_o); else passed++;
    @(negedge clk); #1;
    total++; if (fwd1_hit_o !== 1'b1) $display("FAIL fwd_hit_head: got %0b exp 1", fwd1_hit_o); else passed++;
    total++; if (fwd1_data_o !== 64'hB) $display("FAIL fwd_head_data: got %0h exp b", fwd1_data_o); else passed++;
    total++; if (wdata_o !== 64'hB) $display("FAIL fwd_head_second: got %0h exp b", wdata_o); else passed++;
    @(negedge clk); #1;
    total++; if (fwd1_hit_o !== 1'b0) $display("FAIL fwd_miss_hit: got %0b exp 0", fwd1_hit_o); else passed++;
    total++; if (fwd1_data_o !== 64'h0) $display("FAIL fwd_miss_data: got %0h exp 0", fwd1_data_o); else passed++;
    total++; if (commit_q.size() != 2) $display("FAIL fwd_commit_count: got %0d exp 2", commit_q.size()); else passed++;
    for (int k = 0; k < exp_q.size(); k++) begin
      total++;
      if (k >= commit_q.size() || commit_q[k] !== exp_q[k])
        $display("FAIL fwd_commit_%0d: got %0h exp %0h", k, (k < commit_q.size()) ? commit_q[k] : 69'h0, exp_q[k]);
      else passed++;
    end
    fwd1_addr_i = '0;
    @(negedge clk);
  endtask

  task automatic test_x0();
    commit_q.delete();
    fwd2_addr_i = 5'd0;
    alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 64'hDEAD;
    #1;
    total++; if (alu_ready_o !== 1'b1) $display("FAIL x0_alu_ready: got %0b exp 1", alu_ready_o); else passed++;
    @(negedge clk); idle(); #1;
    total++; if (count_o !== 3'd0) $display("FAIL x0_count: got %0d exp 0", count_o); else passed++;
    total++; if (we_o !== 1'b0) $display("FAIL x0_we: got %0b exp 0", we_o); else passed++;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd9; lsu_data_i = 64'h9;
    alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 64'hBEEF;
    @(negedge clk); idle(); #1;
    total++; if (count_o !== 3'd1) $display("FAIL x0_mixed_count: got %0d exp 1", count_o); else passed++;
    total++; if (fwd2_hit_o !== 1'b0) $display("FAIL x0_fwd2_hit: got %0b exp 0", fwd2_hit_o); else passed++;
    total++; if (waddr_o !== 5'd9) $display("FAIL x0_head_rd: got %0h exp 9", waddr_o); else passed++;
    @(negedge clk); @(negedge clk);
    total++; if (commit_q.size() != 1) $display("FAIL x0_commit_count: got %0d exp 1", commit_q.size()); else passed++;
  endtask

  task automatic test_back_to_back();
    commit_q.delete();
    exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      alu_valid_i = 1'b1;
      alu_rd_i    = 5'(i % 31 + 1);
      alu_data_i  = 64'hC000 + 64'(i);
      exp_q.push_back({alu_rd_i, alu_data_i});
      #1;
      total++; if (alu_ready_o !== 1'b1) $display("FAIL b2b_ready_%0d: got %0b exp 1", i, alu_ready_o); else passed++;
      if (i > 0) begin
        total++; if (count_o !== 3'd1) $display("FAIL b2b_count_%0d: got %0d exp 1", i, count_o); else passed++;
      end
      @(negedge clk);
    end
    idle(); #1;
    total++; if (count_o !== 3'd1) $display("FAIL b2b_tail_count: got %0d exp 1", count_o); else passed++;
    @(negedge clk); #1;
    total++; if (count_o !== 3'd0) $display("FAIL b2b_drained: got %0d exp 0", count_o); else passed++;
    @(negedge clk);
    total++; if (commit_q.size() != 20) $display("FAIL b2b_commit_count: got %0d exp 20", commit_q.size()); else passed++;
    for (int k = 0; k < exp_q.size(); k++) begin
      total++;
      if (k >= commit_q.size() || commit_q[k] !== exp_q[k])
        $display("FAIL b2b_commit_%0d: got %0h exp %0h", k, (k < commit_q.size()) ? commit_q[k] : 69'h0, exp_q[k]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    commit_q.delete();
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd20; lsu_data_i = 64'hE20;
    alu_valid_i = 1'b1; alu_rd_i = 5'd21; alu_data_i = 64'hE21;
    @(negedge clk);
    lsu_rd_i = 5'd22; lsu_data_i = 64'hE22;
    alu_rd_i = 5'd23; alu_data_i = 64'hE23;
    @(negedge clk);
    rst = 1'b1;
    lsu_rd_i = 5'd24; lsu_data_i = 64'hE24;
    alu_rd_i = 5'd25; alu_data_i = 64'hE25;
    #1;
    total++; if (count_o !== 3'd0) $display("FAIL midrst_count: got %0d exp 0", count_o); else passed++;
    total++; if (we_o !== 1'b0) $display("FAIL midrst_we: got %0b exp 0", we_o); else passed++;
    total++; if (lsu_ready_o !== 1'b0) $display("FAIL midrst_lsu_ready: got %0b exp 0", lsu_ready_o); else passed++;
    total++; if (alu_ready_o !== 1'b0) $display("FAIL midrst_alu_ready: got %0b exp 0", alu_ready_o); else passed++;
    @(negedge clk);
    rst = 1'b0; idle(); #1;
    total++; if (count_o !== 3'd0) $display("FAIL midrst_count_after: got %0d exp 0", count_o); else passed++;
    total++; if (we_o !== 1'b0) $display("FAIL midrst_we_after: got %0b exp 0", we_o); else passed++;
    repeat (3) @(negedge clk);
    total++; if (commit_q.size() != 1) $display("FAIL midrst_commit_count: got %0d exp 1", commit_q.size()); else passed++;
    if (commit_q.size() > 0) begin
      total++; if (commit_q[0] !== {5'd20, 64'hE20}) $display("FAIL midrst_commit0: got %0h exp %0h", commit_q[0], {5'd20, 64'hE20}); else passed++;
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    fwd1_addr_i = '0;
    fwd2_addr_i = '0;
    test_reset();
    test_single_push();
    test_dual_push();
    test_order_fwd();
    test_x0();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
